sar_search_ctrl: RTL and testbench

//   Successive-approximation search controller that drives the trial operand of an

---
 rtl/sar_search_ctrl.sv | 137 +++++++++++++
 tb/tb_sar_search_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search controller.
// Drives the trial operand (comparator input A) against an unknown target
// (comparator input B) and resolves the target MSB-first, one bit per cycle.
// Optional feature macro: SAR_EARLY_EXIT_EN -- when defined, a clean eq flag
// ends the search immediately instead of running all WIDTH tests.
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] test_bit;
  logic [WIDTH-1:0] test_acc;
  logic             flags_ok;

  // Candidate bit under test and the flag sanity check.
  assign test_bit = WIDTH'(1) << idx;
  assign flags_ok = ({cmp_lt, cmp_eq, cmp_gt} == 3'b100) ||
                    ({cmp_lt, cmp_eq, cmp_gt} == 3'b010) ||
                    ({cmp_lt, cmp_eq, cmp_gt} == 3'b001);

  // Accumulator value after the current test: keep the bit when trial <= target,
  // drop it when trial > target, wipe everything on a corrupt flag set.
  always_comb begin
    test_acc = acc;
    if (!flags_ok)
      test_acc = '0;
    else if (cmp_lt || cmp_eq)
      test_acc = acc | test_bit;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    case (state)
      IDLE: if (start) next_state = TEST;
      TEST: begin
        if (!flags_ok || idx == '0)
          next_state = DONE;
`ifdef SAR_EARLY_EXIT_EN
        else if (cmp_eq)
          next_state = DONE;
`endif
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: trial is only non-zero while testing, so trial 0 never
  // reaches the comparator during a search.
  always_comb begin
    trial = '0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      TEST: begin
        trial = acc | test_bit;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Search datapath: accumulator, bit index and the reported status.
  // result is loaded on the edge that enters DONE, so it is already valid
  // while the done pulse is high and equals acc for the whole DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            idx    <= IW'(WIDTH - 1);
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
          end
        end
        TEST: begin
          acc <= test_acc;
          if (!flags_ok)
            err <= 1'b1;
          else if (cmp_eq)
            found <= 1'b1;
          if (idx != '0)
            idx <= idx - 1'b1;
          if (next_state == DONE)
            result <= test_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl (WIDTH=4) with a model comparator.
// Expected trial sequences and results are hand-computed and queued by the
// driver; a monitor compares them whenever the DUT is busy or pulses done.
module tb_sar_search_ctrl;

  localparam int W = 4;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] target;
  logic         force_bad;
  logic         cmp_lt, cmp_eq, cmp_gt;
  logic [W-1:0] trial;
  logic         busy, done;
  logic [W-1:0] result;
  logic         found, err;

  typedef struct {
    logic [W-1:0] result;
    logic         found;
    logic         err;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] trial_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cnt   = 0;

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Model comparator: A = trial, B = target, with an override for a corrupt flag set.
  always_comb begin
    cmp_lt = (trial < target);
    cmp_eq = (trial == target);
    cmp_gt = (trial > target);
    if (force_bad) begin
      cmp_lt = 1'b1;
      cmp_eq = 1'b0;
      cmp_gt = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks every trial while busy and every completed search on done.
  always @(negedge clk) begin
    if (rst) begin
      cnt <= 0;
    end else begin
      if (busy) begin
        if (trial_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL trial_unexpected: got %0d, expected none (t=%0t)", trial, $time);
        end else begin
          check("trial", trial, trial_q.pop_front());
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected: got a done pulse, expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result",  result,  e.result);
          check("found",   found,   e.found);
          check("err",     err,     e.err);
          check("latency", cnt + 1, e.lat);
        end
      end
      if (!busy && !done && start)
        cnt <= 0;
      else
        cnt <= cnt + 1;
    end
  end

  task automatic push_trials(input logic [15:0] tl, input int ntr);
    for (int i = 0; i < ntr; i++)
      trial_q.push_back(tl[15-4*i -: 4]);
  endtask

  task automatic push_exp(input logic [W-1:0] res, input logic fnd, input logic e, input int lat);
    exp_t x;
    x.result = res;
    x.found  = fnd;
    x.err    = e;
    x.lat    = lat;
    exp_q.push_back(x);
  endtask

  // Pulse start for one cycle; returns #1 into the first TEST cycle.
  task automatic issue(input logic [W-1:0] tgt);
    @(posedge clk);
    #1;
    target = tgt;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Wait (bounded) for the done cycle, then step into IDLE.
  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done within 30 cycles, expected done", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_trial"},  trial,  0);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_done"},   done,   0);
    check({tag, "_result"}, result, 0);
    check({tag, "_found"},  found,  0);
    check({tag, "_err"},    err,    0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    target    = '0;
    force_bad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // target 10: 8 lt, 12 gt, 10 eq, (11 gt)
    if (EARLY) begin push_trials(16'h8CA0, 3); push_exp(4'd10, 1'b1, 1'b0, 4); end
    else       begin push_trials(16'h8CAB, 4); push_exp(4'd10, 1'b1, 1'b0, 5); end
    issue(4'd10);
    wait_done("t10");

    // target 0: every test gt
    push_trials(16'h8421, 4);
    push_exp(4'd0, 1'b0, 1'b0, 5);
    issue(4'd0);
    wait_done("t0");

    // target 15: every bit kept, eq on the last test
    push_trials(16'h8CEF, 4);
    push_exp(4'd15, 1'b1, 1'b0, 5);
    issue(4'd15);
    wait_done("t15");

    // corrupt flags in the 2nd TEST cycle -> err, done in cycle 3
    push_trials(16'h8C00, 2);
    push_exp(4'd0, 1'b0, 1'b1, 3);
    issue(4'd10);
    @(posedge clk);
    #1;
    force_bad = 1'b1;
    @(posedge clk);
    #1;
    force_bad = 1'b0;
    wait_done("err");

    // reset in the 3rd TEST cycle aborts the search
    push_trials(16'h8C00, 2);
    issue(4'd10);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("midrst");

    // target 5 after the abort: 8 gt, 4 lt, 6 gt, 5 eq
    push_trials(16'h8465, 4);
    push_exp(4'd5, 1'b1, 1'b0, 5);
    issue(4'd5);
    wait_done("t5");

    // start held high: exactly one search per accepted start, none while busy
    for (int s = 0; s < 2; s++) begin
      if (EARLY) begin push_trials(16'h8460, 3); push_exp(4'd6, 1'b1, 1'b0, 4); end
      else       begin push_trials(16'h8467, 4); push_exp(4'd6, 1'b1, 1'b0, 5); end
    end
    @(posedge clk);
    #1;
    target = 4'd6;
    start  = 1'b1;
    begin
      int n = 0;
      int k = 0;
      while (n < 2 && k < 40) begin
        @(posedge clk);
        #1;
        k++;
        if (done) n++;
      end
      start = 1'b0;
      check("hold_done_pulses", n, 2);
    end
    repeat (4) @(posedge clk);
    #1;
    check("hold_idle_busy", busy, 0);
    check("exp_left",   exp_q.size(),   0);
    check("trial_left", trial_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by t=%0t, expected bench to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
